// File: rtl/reg_mem_pkg.sv
// Package: reg_mem_pkg -- sizing defaults and helpers for the register-file memory.
package reg_mem_pkg;

  localparam int unsigned REG_MEM_DATA_WIDTH = 32'd8;
  localparam int unsigned REG_MEM_ADDR_BITS  = 32'd5;

  // Number of words reachable with an address of the given width.
  function automatic int unsigned depth_of(input int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

endpackage

// File: rtl/reg_mem.sv
// Module: reg_mem -- 2**ADDR_BITS x DATA_WIDTH register file.
// Synchronous write, combinational read from one shared address,
// asynchronous active-high clear of every word.
module reg_mem
  import reg_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REG_MEM_DATA_WIDTH,
  parameter int unsigned ADDR_BITS  = REG_MEM_ADDR_BITS
) (
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  input  logic                  clk,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rst
);

  localparam int unsigned DEPTH = depth_of(ADDR_BITS);

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] mem_d [0:DEPTH-1];

  // Next array contents: hold everything, replace only the addressed word when enabled.
  always_comb begin
    mem_d = mem_q;
    if (wen) begin
      mem_d[addr] = data_in;
    end else begin
      mem_d[addr] = mem_q[addr];
    end
  end

  // Storage: reset clears every word immediately and overrides any write edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 32'd0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Zero-latency read; a write becomes visible only after its clock edge.
  assign data_out = mem_q[addr];

endmodule

// File: tb/tb_reg_mem.sv
// Testbench: tb_reg_mem -- directed scenarios plus randomized traffic
// checked against an array reference model of the register file.
module tb_reg_mem;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic          wen;
  logic          clk;
  logic [DW-1:0] data_out;
  logic          rst;

  logic [DW-1:0] model [0:DEPTH-1];

  int n_checks;
  int n_fail;

  reg_mem #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
    .addr     (addr),
    .data_in  (data_in),
    .wen      (wen),
    .clk      (clk),
    .data_out (data_out),
    .rst      (rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it when observed differs from expected.
  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // One clock: set inputs after the falling edge, apply the rising edge, update the model.
  task automatic cycle(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    @(negedge clk);
    addr = a; data_in = d; wen = w;
    @(posedge clk);
    if (w && !rst) model[a] = d;
    #1;
  endtask

  // Read every address with wen low and compare against the model.
  task automatic sweep(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      addr = i[AW-1:0]; wen = 1'b0;
      #1;
      check_eq(tag, data_out, model[i]);
    end
  endtask

  // Fill address k with 223+k (wrapping to 8 bits).
  task automatic fill();
    for (int k = 0; k < DEPTH; k++) begin
      logic [DW-1:0] v;
      v = DW'(223 + k);
      cycle(k[AW-1:0], v, 1'b1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    addr = '0; data_in = '0; wen = 1'b0; rst = 1'b0;
    clear_model();

    // Reset pulse: every address reads zero while held.
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i += 7) begin
      addr = i[AW-1:0];
      #1 check_eq("reset_hold", data_out, 8'h00);
    end
    @(negedge clk); rst = 1'b0;
    sweep("reset_release");

    // Fill pattern: addr 0 -> 223, addr 31 -> 254.
    fill();
    sweep("fill");
    addr = 5'd0;  #1 check_eq("fill_addr0",  data_out, 8'd223);
    addr = 5'd31; #1 check_eq("fill_addr31", data_out, 8'd254);

    // Write inhibit: wen low with data_in 0xAA changes nothing.
    for (int k = 0; k < DEPTH; k++) cycle(k[AW-1:0], 8'hAA, 1'b0);
    sweep("inhibit");

    // Asynchronous reset between edges clears at once.
    @(negedge clk);
    addr = 5'd10; wen = 1'b0;
    #1 check_eq("pre_async_rst", data_out, 8'd233);
    rst = 1'b1;
    #1 check_eq("async_rst_now", data_out, 8'h00);
    clear_model();
    @(negedge clk); rst = 1'b0;
    sweep("after_async_rst");

    // Reset dominates a write edge.
    @(negedge clk);
    rst = 1'b1; addr = 5'd5; data_in = 8'h55; wen = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_vs_write_hold", data_out, 8'h00);
    @(negedge clk); rst = 1'b0; wen = 1'b0;
    #1 check_eq("rst_vs_write_mem5", data_out, 8'h00);

    // Read-during-write at the same address: old before edge, new after.
    cycle(5'd7, 8'h11, 1'b1);
    @(negedge clk);
    addr = 5'd7; data_in = 8'h3C; wen = 1'b1;
    #1 check_eq("rdw_before_edge", data_out, 8'h11);
    @(posedge clk); model[7] = 8'h3C;
    #1 check_eq("rdw_after_edge", data_out, 8'h3C);

    // Overwrite and isolation: refill, then rewrite only addresses 0 and 31.
    fill();
    cycle(5'd0,  8'h5A, 1'b1);
    cycle(5'd31, 8'hC3, 1'b1);
    sweep("isolation");
    addr = 5'd0;  #1 check_eq("overwrite0",  data_out, 8'h5A);
    addr = 5'd31; #1 check_eq("overwrite31", data_out, 8'hC3);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          w;
      a = AW'($urandom_range(0, DEPTH - 1));
      d = DW'($urandom);
      w = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      addr = a; data_in = d; wen = w;
      #1 check_eq("rand_pre", data_out, model[a]);
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        #1 check_eq("rand_async_rst", data_out, 8'h00);
        clear_model();
        #1 rst = 1'b0;
      end
      @(posedge clk);
      if (w) model[a] = d;
      #1 check_eq("rand_post", data_out, model[a]);
    end
    sweep("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
